keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scans a 4x4 active-low matrix keypad one column at a time, classifies every
// full scan pass as NONE / KEY(k) / MULTI, debounces presses and releases over
// DEBOUNCE_SCANS consecutive passes and hands accepted key codes to a consumer
// through a valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES  : cycles each column is driven before its rows are sampled (>= 2)
//   DEBOUNCE_SCANS : identical consecutive passes needed to accept press/release (1..15)
//
// Ports
//   clk_100MHz : system clock, rising edge
//   reset      : synchronous, active-high reset
//   row[3:0]   : keypad rows, active-low, row r on bit row[3-r]
//   col[3:0]   : column drive, active-low one-hot, column c on bit col[3-c]
//   key_code   : hex code of the accepted key, stable while key_valid=1
//   key_valid  : key event available
//   key_ready  : consumer accepts the event
//   key_held   : a debounced key is currently pressed
//   overrun    : sticky, an event was dropped because the previous one was unread
//
// Build option
//   KEYPAD_AUTOREPEAT_EN : when defined, a held key re-emits after 32 further
//                          matching passes, then every 8 passes.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]          DEB_N       = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_CHK,
        ST_HELD,
        ST_RELEASE_CHK
    } state_t;

    // Fixed keypad legend: rows 0..2 of columns 0..2 form the 1..9 block,
    // row 3 holds 0/F/E and column 3 holds A..D.
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        if (c == 2'd3) begin
            code = 4'hA + {2'b00, r};
        end else if (r == 2'd3) begin
            code = (c == 2'd0) ? 4'h0 : ((c == 2'd1) ? 4'hF : 4'hE);
        end else begin
            code = 4'd1 + {2'b00, c} + 4'd3 * {2'b00, r};
        end
        return code;
    endfunction

    // Scan sequencer and pass accumulator
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [1:0]          hits_q, hits_d;          // keys seen so far this pass, saturates at 2
    logic [3:0]          code_acc_q, code_acc_d;  // code of the key seen so far this pass

    // Debounce FSM
    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] count_q, count_d;

    // Output event register
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       overrun_q, overrun_d;

    logic [3:0] row_hit;
    logic       col_last;
    logic       pass_end;
    logic [2:0] col_cnt;
    logic [3:0] col_code;
    logic [2:0] hit_sum;
    logic [1:0] pass_hits;
    logic [3:0] pass_code;
    logic       pass_none;
    logic       pass_key;
    logic       emit;
    logic [3:0] emit_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [5:0] rep_cnt_q, rep_cnt_d;
    logic       rep_armed_q, rep_armed_d;   // first repeat already issued
    logic [5:0] rep_nxt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lines
            assign row_hit[gi] = ~row[3-gi];
            assign col[3-gi]   = (col_idx_q != 2'(gi));
        end
    endgenerate

    assign col_last = (settle_q == SETTLE_LAST);
    assign pass_end = col_last && (col_idx_q == 2'd3);

    // Keys low in the currently driven column. With more than one the code is
    // irrelevant because the pass is MULTI anyway.
    always_comb begin
        col_cnt  = '0;
        col_code = key_map(col_idx_q, 2'd0);
        for (int r = 3; r >= 0; r--) begin
            if (row_hit[r]) begin
                col_cnt  = col_cnt + 3'd1;
                col_code = key_map(col_idx_q, 2'(r));
            end
        end
    end

    // Pass result including the column being sampled right now
    always_comb begin
        hit_sum   = 3'(hits_q) + col_cnt;
        pass_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        pass_code = (col_cnt != 3'd0) ? col_code : code_acc_q;
        pass_none = (pass_hits == 2'd0);
        pass_key  = (pass_hits == 2'd1);
    end

    always_comb begin
        settle_d   = settle_q + SETTLE_W'(1);
        col_idx_d  = col_idx_q;
        hits_d     = hits_q;
        code_acc_d = code_acc_q;
        if (col_last) begin
            settle_d  = '0;
            col_idx_d = col_idx_q + 2'd1;
            if (pass_end) begin
                hits_d     = '0;
                code_acc_d = '0;
            end else begin
                hits_d     = pass_hits;
                code_acc_d = pass_code;
            end
        end
    end

    // Debounce next-state logic, evaluated only on the pass-end cycle
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        count_d   = count_q;
        emit      = 1'b0;
        emit_code = cand_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_nxt     = rep_cnt_q + 6'd1;
`endif
        if (pass_end) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            // Any pass other than a matching one in HELD restarts the repeat timing
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
`endif
            case (state_q)
                ST_RELEASED: begin
                    if (pass_key) begin
                        cand_d    = pass_code;
                        emit_code = pass_code;
                        if (DEB_N == 4'd1) begin
                            state_d = ST_HELD;
                            count_d = '0;
                            emit    = 1'b1;
                        end else begin
                            state_d = ST_PRESS_CHK;
                            count_d = 4'd1;
                        end
                    end
                end
                ST_PRESS_CHK: begin
                    if (pass_key && (pass_code == cand_q)) begin
                        if ((count_q + 4'd1) == DEB_N) begin
                            state_d = ST_HELD;
                            count_d = '0;
                            emit    = 1'b1;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_RELEASED;
                        count_d = '0;
                    end
                end
                ST_HELD: begin
                    if (pass_none) begin
                        if (DEB_N == 4'd1) begin
                            state_d = ST_RELEASED;
                            count_d = '0;
                        end else begin
                            state_d = ST_RELEASE_CHK;
                            count_d = 4'd1;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (pass_key && (pass_code == cand_q)) begin
                        if ((!rep_armed_q && rep_nxt == 6'd32) || (rep_armed_q && rep_nxt == 6'd8)) begin
                            emit        = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end else begin
                            rep_cnt_d   = rep_nxt;
                            rep_armed_d = rep_armed_q;
                        end
                    end
`endif
                end
                ST_RELEASE_CHK: begin
                    if (pass_none) begin
                        if ((count_q + 4'd1) == DEB_N) begin
                            state_d = ST_RELEASED;
                            count_d = '0;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    count_d = '0;
                end
            endcase
        end
    end

    // Event handshake: a handshake frees the slot on the same edge a new event
    // may be loaded, so only an unread, unaccepted event causes a drop.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = emit_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            settle_q    <= '0;
            col_idx_q   <= '0;
            hits_q      <= '0;
            code_acc_q  <= '0;
            state_q     <= ST_RELEASED;
            cand_q      <= '0;
            count_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            settle_q    <= settle_d;
            col_idx_q   <= col_idx_d;
            hits_q      <= hits_d;
            code_acc_q  <= code_acc_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE_CHK);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Self-checking bench for keypad_scan_ctrl with SETTLE_CYCLES=4 and
// DEBOUNCE_SCANS=2 (16-cycle pass). A behavioural keypad pulls rows low for
// pressed keys in the driven column. Expected key codes are queued when a key
// is pressed and compared when the DUT completes a handshake. Cycle index k
// counts negedges after reset release; a pass ends in cycle 15+16n and its
// event is visible in cycle 16+16n.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready  = 1'b0;
    logic       key_held;
    logic       overrun;

    logic [15:0] keys = '0;      // bit c*4+r set = key at column c, row r pressed
    logic [3:0]  sb_q[$];
    logic [3:0]  sb_exp;
    int          n_checks = 0;
    int          n_errors = 0;
    int          k        = 0;
    int          vcount;

    always #5 clk_100MHz = ~clk_100MHz;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // Behavioural keypad matrix
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !col[3-c]) begin
                    row[3-r] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic int kidx(input int c, input int r);
        return c * 4 + r;
    endfunction

    function automatic logic [3:0] exp_col(input int idx);
        logic [3:0] v;
        v = 4'b1000 >> idx;
        return ~v;
    endfunction

    task automatic step();
        @(negedge clk_100MHz);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        keys      = '0;
        key_ready = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        k     = 0;
    endtask

    // Scoreboard consumer: one line per accepted event
    always begin
        @(negedge clk_100MHz);
        #1;
        if (!reset && key_valid && key_ready) begin
            check_eq("sb_pending", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                $display("EVT code=%h exp=%h k=%0d", key_code, sb_exp, k);
                check_eq("sb_code", key_code, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset values and idle column rotation
        apply_reset();
        check_eq("rst_col", col, 4'b0111);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_held", key_held, 0);
        check_eq("rst_overrun", overrun, 0);
        for (int i = 0; i < 36; i++) begin
            check_eq("idle_col", col, exp_col((k / 4) % 4));
            check_eq("idle_valid", key_valid, 0);
            step();
        end

        // Key 5 held three passes, consumer ready
        apply_reset();
        key_ready = 1'b1;
        keys[kidx(1, 1)] = 1'b1;
        sb_q.push_back(4'h5);
        run_to(31);
        check_eq("k5_early", key_valid, 0);
        run_to(32);
        check_eq("k5_valid", key_valid, 1);
        check_eq("k5_code", key_code, 4'h5);
        run_to(33);
        check_eq("k5_pulse", key_valid, 0);
        run_to(47);
        check_eq("k5_held", key_held, 1);
        run_to(48);
        keys = '0;
        run_to(64);
        check_eq("k5_relchk_held", key_held, 1);
        run_to(80);
        check_eq("k5_released", key_held, 0);
        check_eq("k5_no_repeat", key_valid, 0);
        check_eq("k5_overrun", overrun, 0);

        // Key 9 for a single pass, then a proper two-pass press
        apply_reset();
        key_ready = 1'b1;
        keys[kidx(2, 2)] = 1'b1;
        run_to(16);
        keys = '0;
        run_to(32);
        check_eq("k9_glitch_held", key_held, 0);
        check_eq("k9_glitch_valid", key_valid, 0);
        keys[kidx(2, 2)] = 1'b1;
        sb_q.push_back(4'h9);
        run_to(48);
        check_eq("k9_one_pass", key_valid, 0);
        run_to(64);
        check_eq("k9_valid", key_valid, 1);
        check_eq("k9_code", key_code, 4'h9);
        keys = '0;

        // Keys 1 and A together: MULTI
        apply_reset();
        key_ready = 1'b1;
        keys[kidx(0, 0)] = 1'b1;
        keys[kidx(3, 0)] = 1'b1;
        vcount = 0;
        while (k < 64) begin
            if (key_valid) vcount++;
            step();
        end
        check_eq("multi_events", vcount, 0);
        check_eq("multi_overrun", overrun, 0);
        check_eq("multi_held", key_held, 0);
        keys = '0;

        // 3 then E with no consumer: E dropped, overrun set
        apply_reset();
        keys[kidx(2, 0)] = 1'b1;
        sb_q.push_back(4'h3);
        run_to(48);
        check_eq("ovr_valid3", key_valid, 1);
        check_eq("ovr_code3", key_code, 4'h3);
        keys = '0;
        run_to(96);
        keys[kidx(2, 3)] = 1'b1;
        run_to(127);
        check_eq("ovr_before", overrun, 0);
        run_to(128);
        check_eq("ovr_set", overrun, 1);
        check_eq("ovr_valid", key_valid, 1);
        check_eq("ovr_code", key_code, 4'h3);
        run_to(144);
        keys = '0;
        check_eq("ovr_code_hold", key_code, 4'h3);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        run_to(146);
        check_eq("ovr_drained", key_valid, 0);
        check_eq("ovr_sticky", overrun, 1);

        // Event emitted on the same edge as a handshake
        apply_reset();
        keys[kidx(1, 0)] = 1'b1;
        sb_q.push_back(4'h2);
        run_to(48);
        keys = '0;
        run_to(96);
        keys[kidx(1, 2)] = 1'b1;
        sb_q.push_back(4'h8);
        run_to(127);
        check_eq("same_valid2", key_valid, 1);
        check_eq("same_code2", key_code, 4'h2);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check_eq("same_valid8", key_valid, 1);
        check_eq("same_code8", key_code, 4'h8);
        check_eq("same_overrun", overrun, 0);
        step();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check_eq("same_drained", key_valid, 0);
        keys = '0;

        // Reset during column 2 with an event pending
        apply_reset();
        keys[kidx(0, 1)] = 1'b1;
        sb_q.push_back(4'h4);
        run_to(41);
        check_eq("mid_col2", col, 4'b1101);
        check_eq("mid_valid", key_valid, 1);
        reset = 1'b1;
        keys  = '0;
        sb_q.delete();
        step();
        check_eq("mid_rst_col", col, 4'b0111);
        check_eq("mid_rst_valid", key_valid, 0);
        check_eq("mid_rst_code", key_code, 0);
        check_eq("mid_rst_held", key_held, 0);
        check_eq("mid_rst_overrun", overrun, 0);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            check_eq("mid_restart_col", col, exp_col((k / 4) % 4));
            step();
        end
        run_to(48);
        check_eq("mid_quiet", key_valid, 0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
